// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among N_REQ requesters.
// Each product returns to its issuer exactly LATENCY cycles after the handshake.

module mult_share_arbiter_mult #(
  parameter int WA  = 25,
  parameter int WB  = 18,
  parameter int LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  output logic [WA+WB-1:0] p
);
  logic [WA+WB-1:0] pipe [LAT];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else if (CE) begin
      pipe[0] <= (WA+WB)'(a) * (WA+WB)'(b);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[LAT-1];
endmodule

module mult_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH_A = 25,
  parameter int WIDTH_B = 18,
  parameter int LATENCY = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH_A-1:0]   req_a,
  input  logic [N_REQ*WIDTH_B-1:0]   req_b,
  output logic [N_REQ-1:0]           req_ready,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [WIDTH_A+WIDTH_B-1:0] rsp_p,
  output logic                       busy,
  output logic [31:0]                issue_cnt
);
  localparam int IDW = $clog2(N_REQ);
  localparam int WP  = WIDTH_A + WIDTH_B;

  generate
    if (LATENCY < 1 || N_REQ < 2 || N_REQ > 8) begin : g_bad_param
      $fatal(1, "mult_share_arbiter: illegal LATENCY or N_REQ");
    end
  endgenerate

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     idx;
  logic               grant_any;
  logic [WIDTH_A-1:0] mul_a;
  logic [WIDTH_B-1:0] mul_b;
  logic [WP-1:0]      mul_p;
  logic [LATENCY-1:0] tag_v;
  logic [IDW-1:0]     tag_id [LATENCY];

  // Walk from farthest to nearest so the first requester after rr_ptr wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    req_ready = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = IDW'((int'(rr_ptr) + off) % N_REQ);
      if (req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
    if (RST) grant_any = 1'b0;
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  assign mul_a = grant_any ? req_a[grant_id*WIDTH_A +: WIDTH_A] : '0;
  assign mul_b = grant_any ? req_b[grant_id*WIDTH_B +: WIDTH_B] : '0;

  mult_share_arbiter_mult #(.WA(WIDTH_A), .WB(WIDTH_B), .LAT(LATENCY)) u_mult (
    .CLK (CLK),
    .RST (RST),
    .CE  (1'b1),
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_v     <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
      rr_ptr    <= IDW'(N_REQ - 1);
      issue_cnt <= '0;
    end else begin
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
      if (grant_any) begin
        rr_ptr    <= grant_id;
        issue_cnt <= issue_cnt + 32'd1;
      end
    end
  end

  // Outputs are masked during reset so products caught in flight never surface.
  always_comb begin
    rsp_valid = '0;
    if (!RST && tag_v[LATENCY-1]) rsp_valid[tag_id[LATENCY-1]] = 1'b1;
  end

  assign rsp_p = (!RST && tag_v[LATENCY-1]) ? mul_p : '0;
  assign busy  = !RST && (|tag_v);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed checks of mult_share_arbiter against a queue-based model.

module tb_mult_share_arbiter;
  localparam int N = 4, WA = 25, WB = 18, LAT = 3, WP = WA + WB;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*WA-1:0] req_a;
  logic [N*WB-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [WP-1:0]   rsp_p;
  logic            busy;
  logic [31:0]     issue_cnt;

  mult_share_arbiter #(.N_REQ(N), .WIDTH_A(WA), .WIDTH_B(WB), .LATENCY(LAT)) dut (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_p(rsp_p), .busy(busy), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int id; logic [WP-1:0] p; } exp_t;

  exp_t          q[$];
  int            m_ptr = N - 1;
  logic [31:0]   m_cnt = '0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  logic [N-1:0]  s_ready, s_rsp_valid;
  logic [WP-1:0] s_rsp_p;
  logic          s_busy;
  logic [31:0]   s_cnt;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int ptr);
    for (int off = 1; off <= N; off++)
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    return -1;
  endfunction

  function automatic logic [WP-1:0] prod_of(int i);
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    a = req_a[i*WA +: WA];
    b = req_b[i*WB +: WB];
    return WP'(a) * WP'(b);
  endfunction

  task automatic set_req(int i, logic [WA-1:0] a, logic [WB-1:0] b);
    req_a[i*WA +: WA] = a;
    req_b[i*WB +: WB] = b;
  endtask

  // One clock: sample at negedge, compare against the model, advance the model.
  task automatic step();
    int w;
    logic [N-1:0]  er, ev;
    logic [WP-1:0] ep;
    logic          eb;
    @(negedge clk);
    s_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_p = rsp_p;
    s_busy = busy; s_cnt = issue_cnt;
    if (rst) begin
      q.delete();
      m_ptr = N - 1;
      m_cnt = '0;
      check("rst_ready", 64'(s_ready), 64'(0));
      check("rst_rsp_valid", 64'(s_rsp_valid), 64'(0));
      check("rst_rsp_p", 64'(s_rsp_p), 64'(0));
      check("rst_busy", 64'(s_busy), 64'(0));
    end else begin
      eb = (q.size() != 0);
      ev = '0;
      ep = '0;
      if (q.size() != 0 && q[0].due == cyc) begin
        ev[q[0].id] = 1'b1;
        ep = q[0].p;
        void'(q.pop_front());
      end
      w  = pick(req_valid, m_ptr);
      er = '0;
      if (w >= 0) er[w] = 1'b1;
      check("ready", 64'(s_ready), 64'(er));
      check("rsp_valid", 64'(s_rsp_valid), 64'(ev));
      check("rsp_p", 64'(s_rsp_p), 64'(ep));
      check("busy", 64'(s_busy), 64'(eb));
      check("issue_cnt", 64'(s_cnt), 64'(m_cnt));
      if (w >= 0) begin
        q.push_back('{cyc + LAT, w, prod_of(w)});
        m_ptr = w;
        m_cnt = m_cnt + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  int            cnt;
  int            grants[8];
  int            wait_c[N];
  logic [WP-1:0] last_p;
  int            exp_g[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    do_reset();

    // Single max-operand request from requester 2.
    set_req(2, 25'h1FFFFFF, 18'h3FFFF);
    req_valid = 4'b0100;
    cnt = 0;
    step();
    cnt += int'(s_busy);
    req_valid = '0;
    for (int i = 1; i <= 5; i++) begin
      step();
      cnt += int'(s_busy);
      if (i == 3) begin
        check("t1_rsp_valid", 64'(s_rsp_valid), 64'h4);
        check("t1_rsp_p", 64'(s_rsp_p), 64'h7FFFDFC0001);
      end
    end
    check("t1_busy_cycles", 64'(cnt), 64'd3);

    // All four requesters held valid: plain rotation.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, WA'($urandom), WB'($urandom));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      grants[i] = -1;
      for (int j = 0; j < N; j++) if (s_ready[j]) grants[i] = j;
      check("t2_grant", 64'(grants[i]), 64'(exp_g[i]));
    end
    req_valid = '0;
    step();
    check("t2_issue_cnt", 64'(s_cnt), 64'd8);
    for (int i = 0; i < 4; i++) step();

    // Requester 1 alone, back-to-back, B = 0..9.
    do_reset();
    cnt = 0;
    last_p = '0;
    for (int i = 0; i < 14; i++) begin
      req_valid = (i < 10) ? 4'b0010 : 4'b0000;
      set_req(1, 25'h1234567, WB'(i));
      step();
      if (s_rsp_valid == 4'b0010) begin
        cnt++;
        last_p = s_rsp_p;
      end
    end
    check("t3_pulses", 64'(cnt), 64'd10);
    check("t3_last_p", 64'(last_p), 64'hA3D709F);

    // Reset shortly after two issues discards both.
    do_reset();
    set_req(0, 25'd7, 18'd9);
    set_req(3, 25'd5, 18'd11);
    req_valid = 4'b1001;
    step();
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    cnt = 0;
    step();
    cnt += int'(s_rsp_valid != 0);
    step();
    cnt += int'(s_rsp_valid != 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      cnt += int'(s_rsp_valid != 0);
      if (i == 0) begin
        check("t4_busy", 64'(s_busy), 64'd0);
        check("t4_issue_cnt", 64'(s_cnt), 64'd0);
      end
    end
    check("t4_no_rsp", 64'(cnt), 64'd0);
    req_valid = 4'b1001;
    step();
    check("t4_first_grant", 64'(s_ready), 64'h1);
    req_valid = '0;
    for (int i = 0; i < 4; i++) step();

    // Issue and response in the same cycle.
    do_reset();
    set_req(0, 25'd1000, 18'd3000);
    set_req(3, 25'd12, 18'd13);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    step();
    req_valid = 4'b1000;
    step();
    check("t5_ready", 64'(s_ready), 64'h8);
    check("t5_rsp_valid", 64'(s_rsp_valid), 64'h1);
    check("t5_rsp_p", 64'(s_rsp_p), 64'd3000000);
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 2) check("t5_rsp3_p", 64'(s_rsp_p), 64'd156);
    end

    // Random traffic; a requester holds its request until granted.
    do_reset();
    for (int i = 0; i < N; i++) wait_c[i] = 0;
    s_ready = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && s_ready[i]) begin
          check("fair_wait_over_limit", 64'(wait_c[i] > N - 1), 64'd0);
          wait_c[i] = 0;
          req_valid[i] = ($urandom_range(1, 0) == 1);
          set_req(i, WA'($urandom), WB'($urandom));
        end else if (req_valid[i]) begin
          wait_c[i]++;
        end else if ($urandom_range(9, 0) < 4) begin
          req_valid[i] = 1'b1;
          set_req(i, WA'($urandom), WB'($urandom));
        end
      end
      step();
    end
    req_valid = '0;
    for (int i = 0; i < LAT + 2; i++) step();
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
